seq_divider: RTL and testbench

- Sequential restoring divider. It is the inverse datapath of the team's 5-bit array multiplier.
- It splits a 2*WIDTH-bit dividend, such as a multiplier product, by a WIDTH-bit divisor and returns the quotient and remainder.
- It retires one quotient bit per clock and uses a start/busy/done handshake.
- It sits beside the multiplier in the arithmetic unit, so a product can be checked or undone.

---
 rtl/seq_divider.sv | 105 ++++++++++
 tb/tb_seq_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Latency 2*WIDTH clocks start-to-done (divide-by-zero: 1); start is ignored while busy.
module seq_divider #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [DW-1:0]    shreg_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   prem_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [DW-1:0]    quo_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   prem_shift;
  logic [WIDTH:0]   prem_d;
  logic             ge;
  logic [DW-1:0]    shreg_d;

  // shreg_q shifts the dividend out at the top and collects quotient bits at the bottom
  always_comb begin
    prem_shift = (WIDTH + 1)'({prem_q, shreg_q[DW-1]});
    ge         = prem_shift >= {1'b0, dvs_q};
    prem_d     = ge ? (prem_shift - {1'b0, dvs_q}) : prem_shift;
    shreg_d    = {shreg_q[DW-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      shreg_q <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            if (divisor != '0) begin
              shreg_q <= dividend;
              dvs_q   <= divisor;
              prem_q  <= '0;
              count_q <= '0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              quo_q   <= '1;
              rem_q   <= '0;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          shreg_q <= shreg_d;
          prem_q  <= prem_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(DW - 1)) begin
            quo_q   <= shreg_d;
            rem_q   <= prem_d[WIDTH-1:0];
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver queues expected results, monitor checks each done pulse.
module tb_seq_divider;
  localparam int W  = 5;
  localparam int DW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  typedef struct {
    int dd;
    int dv;
    int q;
    int r;
    int dbz;
    int done_cyc;
    int busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  logic [DW-1:0] last_q = '0;
  logic [W-1:0]  last_r = '0;
  logic          last_z = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, all-ones quotient on divide by zero.
  task automatic issue(input int dd, input int dv);
    exp_t e;
    e.dd          = dd;
    e.dv          = dv;
    e.q           = (dv == 0) ? (1 << DW) - 1 : dd / dv;
    e.r           = (dv == 0) ? 0 : dd % dv;
    e.dbz         = (dv == 0) ? 1 : 0;
    e.done_cyc    = cyc + 1 + ((dv == 0) ? 0 : DW);
    e.busy_cycles = (dv == 0) ? 0 : DW;
    start    = 1'b1;
    dividend = DW'(dd);
    divisor  = W'(dv);
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic count_no_done(input int n, input string name);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(name, seen, 0);
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks that outputs hold in between.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
      last_q   = '0;
      last_r   = '0;
      last_z   = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(quotient), e.q);
          check("remainder", 32'(remainder), e.r);
          check("div_by_zero", 32'(div_by_zero), e.dbz);
          check("done_latency", cyc, e.done_cyc);
          check("busy_cycles", busy_cnt, e.busy_cycles);
          check("busy_in_done", 32'(busy), 32'd0);
          if (e.dbz == 0) begin
            check("invariant", 32'(quotient) * 32'(e.dv) + 32'(remainder), e.dd);
            check("rem_lt_div", 32'(32'(remainder) < 32'(e.dv)), 32'd1);
          end
        end
        busy_cnt = 0;
        last_q   = quotient;
        last_r   = remainder;
        last_z   = div_by_zero;
      end else begin
        check("hold_quotient", 32'(quotient), 32'(last_q));
        check("hold_remainder", 32'(remainder), 32'(last_r));
        check("hold_div_by_zero", 32'(div_by_zero), 32'(last_z));
      end
    end
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int dd;
    int dv;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(100, 7);   wait_done(); @(negedge clk);
    issue(1023, 31); wait_done();
    issue(1023, 1);  wait_done();
    issue(45, 9);    wait_done(); @(negedge clk);
    issue(5, 0);     wait_done(); @(negedge clk);
    issue(3, 5);     wait_done();
    issue(0, 13);    wait_done();
    issue(7, 0);     wait_done();
    issue(45, 9);    wait_done(); @(negedge clk);

    // A start pulse mid-run must not disturb the division in flight.
    issue(200, 9);
    @(negedge clk);
    start = 1'b1; dividend = DW'(50); divisor = W'(3);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    count_no_done(15, "single_done_after_ignored_start");

    // Abort a division by asynchronous reset partway through.
    issue(100, 7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_no_done(20, "no_done_after_abort");

    for (int i = 0; i < 1000; i++) begin
      dd = int'($urandom_range(0, 1023));
      dv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
      issue(dd, dv);
      if (dv != 0 && $urandom_range(0, 3) == 0) begin
        start = 1'b1; dividend = DW'($urandom); divisor = W'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
      wait_done();
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (15) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
